// File: rtl/prio_encoder_pipe.sv
// Registered N-bit priority encoder with valid/ready on both sides, multi-hot flag and
// a saturating drop counter. Define ENC_RR_EN for round-robin priority (LSB_FIRST ignored).
module prio_encoder_pipe #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out,
  output logic                 multi,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int W = $clog2(N);

  logic         accept;
  logic         nonzero;
  logic         multi_c;
  logic [W-1:0] win;

  // Handshake: a word is taken when in_valid && in_ready at the rising edge; in_ready is
  // high whenever the output register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign nonzero  = |in;
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_c  = |(in & (in - N'(1)));

`ifdef ENC_RR_EN
  logic [W-1:0]   ptr;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  // Rotate so the search start lands at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    dbl = {in, in} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    win = sum[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept && nonzero) begin
      ptr <= (win == W'(N - 1)) ? '0 : win + W'(1);
    end
  end
`else
  always_comb begin
    win = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in[i]) win = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in[i]) win = W'(i);
      end
    end
  end
`endif

  // out and multi only load on a nonzero accept, so they hold their last value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      multi     <= 1'b0;
      drop_cnt  <= '0;
    end else if (accept) begin
      if (nonzero) begin
        out_valid <= 1'b1;
        out       <= win;
        multi     <= multi_c;
      end else begin
        out_valid <= out_valid && !out_ready;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
